// File: rtl/booth_seq_divider.sv
// Sequential signed divider: non-restoring shift/subtract on operand magnitudes,
// one quotient bit per clock, with sign fix-up, divide-by-zero and overflow flags.
module booth_seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH:0]   a_q, m_q;
  logic [WIDTH-1:0] q_q;
  logic [CW-1:0]    count_q;
  logic             sign_dd, sign_dv, dz_q, ovf_q;

  logic [WIDTH:0]   shifted_a, a_step;
  logic [WIDTH-1:0] q_step, rem_mag, dd_abs, dv_abs;

  // NOTE: state and datapath registers use non-blocking assignments so every
  // register samples pre-edge values regardless of evaluation order.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_next = state;
    if (mode) begin
      state_next = (divisor == '0) ? FIX : RUN;
    end else begin
      case (state)
        RUN:     if (count_q == CW'(1)) state_next = FIX;
        FIX:     state_next = DONE;
        default: state_next = state;
      endcase
    end
  end

  always_comb begin
    dd_abs    = dividend[WIDTH-1] ? -dividend : dividend;
    dv_abs    = divisor[WIDTH-1]  ? -divisor  : divisor;
    // Sign of the partial remainder before the shift selects add or subtract.
    shifted_a = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
    a_step    = a_q[WIDTH] ? shifted_a + m_q : shifted_a - m_q;
    q_step    = {q_q[WIDTH-2:0], ~a_step[WIDTH]};
    // Final restore only needs the low bits: the true remainder is below |divisor|.
    rem_mag   = a_q[WIDTH] ? a_q[WIDTH-1:0] + m_q[WIDTH-1:0] : a_q[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q         <= '0;
      m_q         <= '0;
      q_q         <= '0;
      count_q     <= '0;
      sign_dd     <= 1'b0;
      sign_dv     <= 1'b0;
      dz_q        <= 1'b0;
      ovf_q       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else if (mode) begin
      a_q         <= '0;
      m_q         <= {1'b0, dv_abs};
      q_q         <= dd_abs;
      count_q     <= CW'(WIDTH);
      sign_dd     <= dividend[WIDTH-1];
      sign_dv     <= divisor[WIDTH-1];
      dz_q        <= (divisor == '0);
      ovf_q       <= (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);
      busy        <= (divisor != '0);
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          a_q     <= a_step;
          q_q     <= q_step;
          count_q <= count_q - CW'(1);
        end
        FIX: begin
          busy <= 1'b0;
          done <= 1'b1;
          if (dz_q) begin
            quotient    <= '1;
            remainder   <= sign_dd ? -q_q : q_q;
            div_by_zero <= 1'b1;
          end else begin
            // MIN / -1 wraps naturally: magnitude 2^(WIDTH-1) reads back as MIN.
            quotient    <= (sign_dd ^ sign_dv) ? -q_q : q_q;
            remainder   <= sign_dd ? -rem_mag : rem_mag;
            overflow    <= ovf_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_seq_divider.sv
// Directed-vector bench for booth_seq_divider: result table plus reset,
// restart and hold sequences.
module tb_booth_seq_divider;

  logic       clk = 1'b0;
  logic       reset, mode;
  logic [7:0] dividend, divisor, quotient, remainder;
  logic       busy, done, div_by_zero, overflow;

  int checks = 0;
  int errors = 0;

  booth_seq_divider #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .mode(mode),
    .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int dd, dv, q, r, dz, ov, lat;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Pulse mode for one edge, then count edges until done (bounded).
  task automatic start_op(input int dd, input int dv);
    @(negedge clk);
    dividend = 8'(dd);
    divisor  = 8'(dv);
    mode     = 1'b1;
    @(posedge clk);
    #1;
    mode = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!done && cycles < 20) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic check_outputs(input string tag, input int q, input int r,
                               input int dz, input int ov);
    check({tag, " done"}, int'(done), 1);
    check({tag, " busy"}, int'(busy), 0);
    check({tag, " quotient"}, int'($signed(quotient)), q);
    check({tag, " remainder"}, int'($signed(remainder)), r);
    check({tag, " div_by_zero"}, int'(div_by_zero), dz);
    check({tag, " overflow"}, int'(overflow), ov);
  endtask

  initial begin
    int cyc;
    vecs[0] = '{ 100,    7,   14,    2, 0, 0, 9};
    vecs[1] = '{-100,    7,  -14,   -2, 0, 0, 9};
    vecs[2] = '{ 100,   -7,  -14,    2, 0, 0, 9};
    vecs[3] = '{ -87,  127,    0,  -87, 0, 0, 9};
    vecs[4] = '{-127, -127,    1,    0, 0, 0, 9};
    vecs[5] = '{-128,  127,   -1,   -1, 0, 0, 9};
    vecs[6] = '{-128,    0,   -1, -128, 1, 0, 1};
    vecs[7] = '{-128,   -1, -128,    0, 0, 1, 9};
    vecs[8] = '{-128,    1, -128,    0, 0, 0, 9};
    vecs[9] = '{   7,  100,    0,    7, 0, 0, 9};

    reset = 1'b1; mode = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset quotient", int'(quotient), 0);
    check("reset remainder", int'(remainder), 0);
    check("reset flags", int'({busy, done, div_by_zero, overflow}), 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("idle hold", int'({quotient, remainder, busy, done}), 0);

    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("v%0d %0d/%0d", i, vecs[i].dd, vecs[i].dv);
      start_op(vecs[i].dd, vecs[i].dv);
      check({tag, " busy after load"}, int'(busy), vecs[i].dz ? 0 : 1);
      check({tag, " done after load"}, int'(done), 0);
      wait_done(cyc);
      check({tag, " latency"}, cyc, vecs[i].lat);
      check_outputs(tag, vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].ov);
    end

    // Result holds in DONE while mode stays low.
    repeat (5) @(posedge clk);
    #1;
    check_outputs("hold", 0, 7, 0, 0);

    // Reset during RUN cycle 4 clears everything on the next edge.
    start_op(45, 36);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("mid-run reset quotient", int'(quotient), 0);
    check("mid-run reset remainder", int'(remainder), 0);
    check("mid-run reset flags", int'({busy, done, div_by_zero, overflow}), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("idle after reset done", int'(done), 0);

    // A second mode pulse mid-run restarts the operation.
    start_op(100, 7);
    repeat (4) @(posedge clk);
    start_op(45, 36);
    wait_done(cyc);
    check("restart latency", cyc, 9);
    check_outputs("restart 45/36", 1, 9, 0, 0);

    // Mode held high restarts every edge; completion follows the last sampled edge.
    @(negedge clk);
    dividend = 8'(-100); divisor = 8'(7); mode = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    mode = 1'b0;
    check("held mode busy", int'(busy), 1);
    wait_done(cyc);
    check("held mode latency", cyc, 9);
    check_outputs("held mode -100/7", -14, -2, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
